// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// One FSM walks start, data (LSB first), optional parity and 1 or 2 stop bits.
// A baud counter holds every bit on TXD for DIV+1 clock cycles.
// Frame settings are copied into shadow registers on accept, so the host
// may change its inputs while a frame is in flight.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic [DATA_BITS-1:0] TXDATA,
  input  logic                 TX_RQ,
  input  logic [1:0]           PAR_MODE,
  input  logic                 STOP2,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic                 TXD,
  output logic                 TX_BUSY,
  output logic                 TX_DONE
);

  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Shadow copies of the frame settings, loaded on accept.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  logic advance;
  logic last_data;
  logic par_en;
  logic par_bit;

  // Per-frame decodes of the shadowed settings.
  assign advance   = (baud_q == div_q);
  assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
  assign par_en    = (par_q == 2'd1) || (par_q == 2'd2);
  assign par_bit   = (^data_q) ^ (par_q == 2'd2);

  // Next-state logic: FSM sequencing, baud and bit counters, shadow capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    div_d   = div_q;

    unique case (state_q)
      S_IDLE: begin
        if (TX_RQ) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          data_d  = TXDATA;
          par_d   = PAR_MODE;
          stop2_d = STOP2;
          div_d   = DIV;
        end
      end
      S_START: begin
        if (advance) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (advance) begin
          baud_d = '0;
          if (last_data) begin
            bit_d   = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (advance) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (advance) begin
          baud_d = '0;
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
          end else begin
            bit_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the state being entered, so TXD changes on
  // the same edge as the FSM.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_d];
      S_PARITY: txd_d = par_bit;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  // Control state with synchronous reset; reset also aborts a frame silently.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (R) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Shadow registers for the frame settings.
  always_ff @(posedge CLK) begin
    // NOTE: these carry no reset; they are always loaded on accept before
    // anything reads them, so resetting them buys nothing.
    data_q  <= data_d;
    par_q   <= par_d;
    stop2_q <= stop2_d;
    div_q   <= div_d;
  end

  assign TXD     = txd_q;
  assign TX_BUSY = busy_q;
  assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8-bit and a 7-bit instance share
// clock, reset and frame settings; each has its own data and request.
// Expected TXD sequences are hand-written strings, one char per bit period.
module tb_uart_tx_frame;

  logic        clk;
  logic        r;
  logic [7:0]  data8;
  logic [6:0]  data7;
  logic        rq8;
  logic        rq7;
  logic [1:0]  par_mode;
  logic        stop2;
  logic [15:0] div;
  logic        txd8, busy8, done8;
  logic        txd7, busy7, done7;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_BITS(8), .DIV_WIDTH(16)) dut8 (
    .CLK(clk), .R(r), .TXDATA(data8), .TX_RQ(rq8), .PAR_MODE(par_mode),
    .STOP2(stop2), .DIV(div), .TXD(txd8), .TX_BUSY(busy8), .TX_DONE(done8)
  );

  uart_tx_frame #(.DATA_BITS(7), .DIV_WIDTH(16)) dut7 (
    .CLK(clk), .R(r), .TXDATA(data7), .TX_RQ(rq7), .PAR_MODE(par_mode),
    .STOP2(stop2), .DIV(div), .TXD(txd7), .TX_BUSY(busy7), .TX_DONE(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit sel7);
    if (sel7) begin
      check({tag, ".txd"}, txd7, 1);
      check({tag, ".busy"}, busy7, 0);
      check({tag, ".done"}, done7, 0);
    end else begin
      check({tag, ".txd"}, txd8, 1);
      check({tag, ".busy"}, busy8, 0);
      check({tag, ".done"}, done8, 0);
    end
  endtask

  // Called right after the accept edge. Checks every cycle of the frame
  // against 'bits', then the TX_DONE cycle. After the first sampled cycle the
  // data input is changed to mid_data and, unless hold is set, TX_RQ drops.
  task automatic expect_frame(input bit sel7, input string tag, input string bits,
                              input int dv, input logic [7:0] mid_data, input bit hold);
    logic t, b, d;
    bit first;
    first = 1'b1;
    for (int i = 0; i < bits.len(); i++) begin
      for (int c = 0; c <= dv; c++) begin
        t = sel7 ? txd7 : txd8;
        b = sel7 ? busy7 : busy8;
        d = sel7 ? done7 : done8;
        check($sformatf("%s.bit%0d.c%0d.txd", tag, i, c), t, (bits[i] == 8'h31));
        check($sformatf("%s.bit%0d.c%0d.busy", tag, i, c), b, 1);
        check($sformatf("%s.bit%0d.c%0d.done", tag, i, c), d, 0);
        if (first) begin
          first = 1'b0;
          if (sel7) data7 = mid_data[6:0];
          else      data8 = mid_data;
          if (!hold) begin
            if (sel7) rq7 = 1'b0;
            else      rq8 = 1'b0;
          end
        end
        step();
      end
    end
    t = sel7 ? txd7 : txd8;
    b = sel7 ? busy7 : busy8;
    d = sel7 ? done7 : done8;
    check({tag, ".end.txd"}, t, 1);
    check({tag, ".end.busy"}, b, 0);
    check({tag, ".end.done"}, d, 1);
  endtask

  initial begin
    r        = 1'b1;
    rq8      = 1'b1;
    rq7      = 1'b1;
    data8    = 8'h00;
    data7    = 7'h00;
    par_mode = 2'd0;
    stop2    = 1'b0;
    div      = 16'd0;

    // Reset held 3 cycles with requests high: no start bit may appear.
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("rst%0d.d8", i), 1'b0);
      check_idle($sformatf("rst%0d.d7", i), 1'b1);
    end
    r   = 1'b0;
    rq8 = 1'b0;
    rq7 = 1'b0;
    step();
    check_idle("post_rst.d8", 1'b0);
    check_idle("post_rst.d7", 1'b1);

    // 8N1, DIV=0, 0xA5; the input is corrupted mid-frame to prove shadowing.
    data8 = 8'hA5; par_mode = 2'd0; stop2 = 1'b0; div = 16'd0; rq8 = 1'b1;
    step();
    expect_frame(1'b0, "8n1_a5", "0101001011", 0, 8'h5A, 1'b0);
    step();
    check_idle("8n1_a5.after", 1'b0);

    // 8E1, DIV=3, 0x07: three ones -> even parity bit 1; 44 busy cycles.
    data8 = 8'h07; par_mode = 2'd1; stop2 = 1'b0; div = 16'd3; rq8 = 1'b1;
    step();
    par_mode = 2'd0; div = 16'd0;
    expect_frame(1'b0, "8e1_07", "01110000011", 3, 8'hFF, 1'b0);
    step();
    check_idle("8e1_07.after", 1'b0);

    // 7O2 on the 7-bit instance, DIV=1, 0x00: odd parity 1, two stops; 22 cycles.
    data7 = 7'h00; par_mode = 2'd2; stop2 = 1'b1; div = 16'd1; rq7 = 1'b1;
    step();
    stop2 = 1'b0; par_mode = 2'd0;
    expect_frame(1'b1, "7o2_00", "00000000111", 1, 8'h7F, 1'b0);
    step();
    check_idle("7o2_00.after", 1'b1);
    check_idle("7o2_00.d8quiet", 1'b0);

    // Reserved parity mode behaves as none: 8-bit 0x81, DIV=0, 8?1.
    data8 = 8'h81; par_mode = 2'd3; stop2 = 1'b0; div = 16'd0; rq8 = 1'b1;
    step();
    expect_frame(1'b0, "8r1_81", "0100000011", 0, 8'h81, 1'b0);
    step();

    // TX_RQ held: 0x3C then 0xC3 (changed during frame 1), 1 idle cycle apart.
    data8 = 8'h3C; par_mode = 2'd0; stop2 = 1'b0; div = 16'd0; rq8 = 1'b1;
    step();
    expect_frame(1'b0, "hold_3c", "0001111001", 0, 8'hC3, 1'b1);
    step();
    expect_frame(1'b0, "hold_c3", "0110000111", 0, 8'hC3, 1'b0);
    step();
    check_idle("hold.after", 1'b0);

    // Reset during the data bits of a DIV=2 frame, then a clean new frame.
    data8 = 8'h5A; par_mode = 2'd0; stop2 = 1'b0; div = 16'd2; rq8 = 1'b1;
    step();
    rq8 = 1'b0;
    check("abort.start_txd", txd8, 0);
    for (int i = 0; i < 5; i++) step();
    check("abort.in_data_busy", busy8, 1);
    r = 1'b1;
    step();
    r = 1'b0;
    check_idle("abort.rst", 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle($sformatf("abort.quiet%0d", i), 1'b0);
    end
    rq8 = 1'b1;
    step();
    expect_frame(1'b0, "abort.new_5a", "0010110101", 2, 8'h00, 1'b0);
    step();
    check_idle("abort.new.after", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the next generation of the fixed 8N1 TX block. Adds generic data width, a runtime baud divider, optional even/odd parity, selectable 1 or 2 stop bits and a done pulse. It sits between the host-side request/data interface and the serial TXD line, and replaces the counter+mux TX datapath with a single FSM plus bit and baud counters.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
DIV_WIDTH, 16, width of the baud divider input.

Ports:
CLK  input  1  single clock for the block; all logic on posedge CLK.
R  input  1  synchronous reset, active-high.
TXDATA  input  DATA_BITS  frame payload; captured on accept.
TX_RQ  input  1  transmit request; sampled only while TX_BUSY=0.
PAR_MODE  input  2  0=none, 1=even, 2=odd, 3=reserved (treated as none); captured on accept.
STOP2  input  1  0=one stop bit, 1=two stop bits; captured on accept.
DIV  input  DIV_WIDTH  bit period minus 1, in CLK cycles; captured on accept.
TXD  output  1  serial line, registered output; idle high.
TX_BUSY  output  1  high while a frame is in progress.
TX_DONE  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high. With R=1 at a posedge, the next state is TXD=1, TX_BUSY=0, TX_DONE=0, FSM=IDLE, and all counters are 0. R has priority over every other input.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when the captured mode is none or reserved) -> STOP -> IDLE.
- Accept: when the FSM is in IDLE and TX_RQ=1 at edge k, the block latches TXDATA, PAR_MODE, STOP2 and DIV into shadow registers. From edge k+1: FSM=START, TX_BUSY=1, TXD=0.
- Bit period: every bit, including start, parity and stop, drives TXD for exactly DIV+1 cycles. DIV=0 gives one cycle per bit.
- The baud counter counts 0..DIV_shadow. The bit advances when the counter equals DIV_shadow. The counter wraps to 0 on each advance.
- DATA: bit i = TXDATA_shadow[i], i = 0..DATA_BITS-1. The bit counter clears on entry to DATA and on entry to STOP.
- PARITY: even mode sends the XOR of all data bits. Odd mode sends the inverse of that XOR.
- STOP: TXD=1 for 1 or 2 bit periods, according to STOP2_shadow.
- Completion: at the edge that ends the last stop bit, FSM=IDLE, TX_BUSY=0 and TX_DONE=1 for exactly one cycle. TXD stays 1.
- Busy time: TX_BUSY is high for exactly (1 + DATA_BITS + P + S) * (DIV+1) cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back: TX_RQ is evaluated in the TX_DONE cycle (the FSM is IDLE). If TX_RQ=1 there, the next start bit begins the following cycle. This gives exactly one idle-high cycle between frames.
- While busy: TX_RQ is ignored, with no queuing. Changes to TXDATA, PAR_MODE, STOP2 and DIV do not affect the current frame.
- Reset mid-frame: the frame is aborted. TXD=1 and TX_BUSY=0 on the next edge. No TX_DONE pulse is generated.
- TX_RQ held high continuously: frames repeat with a 1-cycle gap, and each frame captures the current inputs.

Test Plan:
- Reset: hold R for 3 cycles with TX_RQ=1 -> TXD=1, TX_BUSY=0 and TX_DONE=0 throughout, and no start bit appears.
- 8N1 (PAR_MODE=0, STOP2=0), DIV=0, TXDATA=0xA5, one-cycle TX_RQ -> TXD sequence 0,1,0,1,0,0,1,0,1,1. TX_BUSY high for 10 cycles, then TX_DONE pulses once.
- 8E1, DIV=3, TXDATA=0x07 -> each bit lasts 4 cycles, parity bit = 1, 11 bits, TX_BUSY high for 44 cycles.
- DATA_BITS=7 instance, 7O2, DIV=1, TXDATA=0x00 -> parity bit = 1, two stop bits, TX_BUSY high for 22 cycles.
- TX_RQ held high with TXDATA changed from 0x3C to 0xC3 mid-frame -> the first frame carries 0x3C, the second carries 0xC3, and exactly 1 idle-high cycle separates them.
- R asserted during the data bits of a DIV=2 frame -> TXD=1 and TX_BUSY=0 on the next edge, no TX_DONE pulse, and a new TX_RQ starts a clean frame.
